// File: rtl/rv_elastic_buffer.sv
// -----------------------------------------------------------------------------
// rv_elastic_buffer
//   DEPTH-entry ready/valid elastic buffer (FIFO) placed between pipeline
//   stages. It sustains one transfer per cycle in each direction, absorbs up to
//   DEPTH cycles of consumer backpressure and reports its occupancy.
//
//   All handshake outputs are decoded from registered state only: there is no
//   combinational path from out_ready to in_ready, nor from in_* to out_*.
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst_n        asynchronous active-low reset
//   flush        synchronous clear of all entries (dominates push/pop)
//   in_valid     producer has data
//   in_ready     buffer can accept data this cycle
//   in_data      producer payload
//   out_valid    buffer holds data for the consumer
//   out_ready    consumer accepts data this cycle
//   out_data     payload at the head of the buffer
//   count        current occupancy, 0..DEPTH
//   almost_full  count >= AF_LEVEL
// -----------------------------------------------------------------------------
module rv_elastic_buffer #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned AF_LEVEL = DEPTH - 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         almost_full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    // Low while in reset; holds in_ready low until the first edge after release.
    logic             live_q;

    logic push;
    logic pop;

    // Handshake and status decode from registered state only.
    always_comb begin
        in_ready    = live_q && (count_q != CNT_W'(DEPTH));
        out_valid   = (count_q != '0);
        out_data    = mem_q[rd_ptr_q];
        count       = count_q;
        almost_full = (count_q >= CNT_W'(AF_LEVEL));
        push        = in_valid  && in_ready;
        pop         = out_valid && out_ready;
    end

    // Next-state for pointers and occupancy; flush overrides any transfer.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            live_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            live_q   <= 1'b1;
        end
    end

    // Payload storage; not reset, a flushed push is never written.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_rv_elastic_buffer.sv
// -----------------------------------------------------------------------------
// tb_rv_elastic_buffer
//   Directed, self-checking bench for rv_elastic_buffer (DATA_W=32, DEPTH=4,
//   AF_LEVEL=3). Inputs change and outputs are sampled 1 time unit after the
//   rising edge.
// -----------------------------------------------------------------------------
module tb_rv_elastic_buffer;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [2:0]  count;
    logic        almost_full;

    int checks;
    int failures;

    rv_elastic_buffer #(
        .DATA_W   (32),
        .DEPTH    (4),
        .AF_LEVEL (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .count       (count),
        .almost_full (almost_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        #3;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || count !== 3'd0 || almost_full !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got v=%b r=%b c=%0d af=%b exp v=0 r=0 c=0 af=0",
                     out_valid, in_ready, count, almost_full);
        end
        step();
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready_held got %b exp 0", in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL release_before_edge got in_ready=%b exp 0", in_ready);
        end
        step();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || count !== 3'd0) begin
            failures++;
            $display("FAIL release_first_edge got r=%b v=%b c=%0d exp r=1 v=0 c=0",
                     in_ready, out_valid, count);
        end
    endtask

    task automatic test_pass_through();
        out_ready = 1'b1; in_valid = 1'b1; in_data = 32'hA5A5_0001;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hA5A5_0001 || count !== 3'd1) begin
            failures++;
            $display("FAIL pass_visible got v=%b d=%h c=%0d exp v=1 d=a5a50001 c=1",
                     out_valid, out_data, count);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || count !== 3'd0) begin
            failures++;
            $display("FAIL pass_popped got v=%b c=%0d exp v=0 c=0", out_valid, count);
        end
    endtask

    task automatic test_fill();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h0000_0010 + 32'(i);
            step();
            checks++;
            if (count !== 3'(i + 1) || almost_full !== (i >= 2) || in_ready !== (i != 3)) begin
                failures++;
                $display("FAIL fill_push%0d got c=%0d af=%b r=%b exp c=%0d af=%b r=%b",
                         i, count, almost_full, in_ready, i + 1, (i >= 2), (i != 3));
            end
        end
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (out_data !== 32'h0000_0010 || out_valid !== 1'b1 || count !== 3'd4 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL fill_hold%0d got d=%h v=%b c=%0d r=%b exp d=00000010 v=1 c=4 r=0",
                         i, out_data, out_valid, count, in_ready);
            end
        end
    endtask

    task automatic test_full_pop();
        logic [31:0] exp_head [4];
        logic [2:0]  exp_cnt  [4];
        exp_head[0] = 32'h0000_0011; exp_cnt[0] = 3'd3;
        exp_head[1] = 32'h0000_0012; exp_cnt[1] = 3'd3;
        exp_head[2] = 32'h0000_0013; exp_cnt[2] = 3'd2;
        exp_head[3] = 32'hDEAD_BEEF; exp_cnt[3] = 3'd1;
        out_ready = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            step();
            // DEAD_BEEF is refused at the first edge and taken at the second.
            if (i == 1) in_valid = 1'b0;
            checks++;
            if (out_data !== exp_head[i] || count !== exp_cnt[i] || out_valid !== 1'b1) begin
                failures++;
                $display("FAIL full_pop_edge%0d got d=%h c=%0d v=%b exp d=%h c=%0d v=1",
                         i, out_data, count, out_valid, exp_head[i], exp_cnt[i]);
            end
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || count !== 3'd0) begin
            failures++;
            $display("FAIL full_pop_drained got v=%b c=%0d exp v=0 c=0", out_valid, count);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_stream();
        out_ready = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            in_data = 32'h1234_5678 + 32'(k);
            step();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 32'h1234_5678 + 32'(k) ||
                count !== 3'd1 || in_ready !== 1'b1) begin
                failures++;
                $display("FAIL stream_cycle%0d got v=%b d=%h c=%0d r=%b exp v=1 d=%h c=1 r=1",
                         k, out_valid, out_data, count, in_ready, 32'h1234_5678 + 32'(k));
            end
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0 || count !== 3'd0) begin
            failures++;
            $display("FAIL stream_drain got v=%b c=%0d exp v=0 c=0", out_valid, count);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h0000_0100 + 32'(i);
            step();
        end
        checks++;
        if (count !== 3'd3 || almost_full !== 1'b1) begin
            failures++;
            $display("FAIL flush_prefill got c=%0d af=%b exp c=3 af=1", count, almost_full);
        end
        flush = 1'b1; in_valid = 1'b1; in_data = 32'hCAFE_F00D;
        step();
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || almost_full !== 1'b0) begin
            failures++;
            $display("FAIL flush_clear got c=%0d v=%b r=%b af=%b exp c=0 v=0 r=1 af=0",
                     count, out_valid, in_ready, almost_full);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b0 || count !== 3'd0) begin
                failures++;
                $display("FAIL flush_idle%0d got v=%b c=%0d exp v=0 c=0", i, out_valid, count);
            end
        end
        in_valid = 1'b1; in_data = 32'h0000_0055;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h0000_0055 || count !== 3'd1) begin
            failures++;
            $display("FAIL flush_next_head got v=%b d=%h c=%0d exp v=1 d=00000055 c=1",
                     out_valid, out_data, count);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || count !== 3'd0) begin
            failures++;
            $display("FAIL flush_final_pop got v=%b c=%0d exp v=0 c=0", out_valid, count);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h0000_0200 + 32'(i);
            step();
        end
        in_valid = 1'b1; in_data = 32'h0000_0202;
        checks++;
        if (count !== 3'd2) begin
            failures++;
            $display("FAIL areset_prefill got c=%0d exp 2", count);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || count !== 3'd0 || in_ready !== 1'b0 || almost_full !== 1'b0) begin
            failures++;
            $display("FAIL areset_immediate got v=%b c=%0d r=%b af=%b exp v=0 c=0 r=0 af=0",
                     out_valid, count, in_ready, almost_full);
        end
        step();
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0 || count !== 3'd0) begin
            failures++;
            $display("FAIL areset_release got r=%b c=%0d exp r=0 c=0", in_ready, count);
        end
        step();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || count !== 3'd0) begin
            failures++;
            $display("FAIL areset_first_edge got r=%b v=%b c=%0d exp r=1 v=0 c=0",
                     in_ready, out_valid, count);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_pass_through();
        test_fill();
        test_full_pop();
        test_stream();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #20000;
        $display("FAIL watchdog_timeout got time=%0t exp completion", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rv_elastic_buffer.md
Name: rv_elastic_buffer

Overview:
- Parametrised successor to the single-entry ready/valid pipeline register. It is a DEPTH-entry elastic buffer with ready/valid on both sides.
- Sustains one transfer per cycle in each direction, absorbs DEPTH cycles of downstream backpressure without loss, and reports occupancy.
- Adds a synchronous flush and an almost-full threshold.
- Sits between pipeline stages where a single register cannot hide consumer stalls.

Parameters:
- DATA_W, 32, payload width in bits.
- DEPTH, 4, number of storage entries; power of two, >= 2.
- AF_LEVEL, DEPTH-1, occupancy at or above which almost_full asserts; range 1..DEPTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of all entries.
- in_valid  input  1  producer has data.
- in_ready  output  1  buffer can accept data this cycle.
- in_data  input  DATA_W  producer payload.
- out_valid  output  1  buffer holds data for consumer.
- out_ready  input  1  consumer accepts data this cycle.
- out_data  output  DATA_W  payload at head of buffer.
- count  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- almost_full  output  1  count >= AF_LEVEL.

Behaviour:
- Reset (rst_n low, async): count=0, read/write pointers=0, out_valid=0, in_ready=0 while rst_n low, almost_full=0. out_data is don't-care but must not be X-propagating from control; storage is not cleared.
- After reset release: in_ready=1 from the first rising edge.
- Push = in_valid && in_ready. Pop = out_valid && out_ready. Both are sampled at the rising edge.
- in_ready = (count != DEPTH). It depends only on registered state and is never combinational from out_ready. When the buffer is full, a same-cycle pop does not enable a push; the push is accepted one cycle later.
- out_valid = (count != 0). out_data = storage[rd_ptr]. Both depend only on registered state, with no combinational path from in_* to out_*.
- Latency: a word pushed at edge N is visible on out_data/out_valid after edge N, so it can pop at edge N+1. Minimum latency is 1 cycle, the same as the single register.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- count update per edge:
  - push only: +1
  - pop only: -1
  - push and pop: unchanged
  - neither: unchanged
- Simultaneous push and pop at count=1: the head is consumed, the new word becomes the head, and out_valid stays 1.
- Ordering is strict FIFO; no word is dropped, duplicated or reordered.
- Producer rule: in_valid and in_data are held stable until the push. The buffer does not depend on this rule for correctness.
- Flush (sync, high at edge): count=0 and both pointers=0. Any push or pop that cycle is ignored: the pushed word is discarded and no pop is counted. Flush dominates all other events. After the flush edge, out_valid=0 and in_ready=1.
- almost_full is registered-equivalent: it is derived from count, with no combinational input path.
- Reset mid-transfer: all state is cleared immediately, with no completion of in-flight handshakes.

Test Plan:
- Pass-through: out_ready=1; push 32'hA5A5_0001. Required: out_valid=1 with out_data=32'hA5A5_0001 the cycle after the push, popped next edge, count returns to 0.
- Fill/backpressure: out_ready=0; push 32'h0000_0010..32'h0000_0013 on consecutive cycles (DEPTH=4). Required:
  - in_ready=0 after the 4th push and count=4.
  - almost_full=1 from count=3.
  - out_data holds 32'h0000_0010 for 5 idle cycles.
- Full with simultaneous pop: at count=4, raise out_ready with in_valid=1 and in_data=32'hDEAD_BEEF. Required:
  - First edge: 32'h0000_0010 popped, DEAD_BEEF not accepted, count=3.
  - Next edge: DEAD_BEEF accepted.
  - Drain order: 11, 12, 13, DEAD_BEEF.
- Streaming wrap: out_ready=1, in_valid=1 continuously for 20 cycles with an incrementing payload from 32'h1234_5678. Required: one transfer per cycle, count constant at 1 after startup, output sequence identical to input across pointer wrap.
- Flush: fill 3 entries, then assert flush with in_valid=1 and in_data=32'hCAFE_F00D. Required: count=0, out_valid=0 next cycle, CAFE_F00D never appears on out_data.
- Async reset mid-stream: pull rst_n low between edges while count=2. Required: out_valid=0, count=0 and in_ready=0 immediately, without waiting for a clock edge; in_ready=1 after the first edge post-release.
